sram_async_ctrl: RTL and testbench



---
 rtl/cram_sram_pkg.sv | 44 ++++
 rtl/sram_async_ctrl.sv | 132 +++++++++++++
 tb/tb_sram_async_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cram_sram_pkg.sv
// cram_sram_pkg: shared types, default timing and sizing helpers for the async SRAM controller
package cram_sram_pkg;

  typedef enum logic [3:0] {
    ST_RST,
    ST_IDLE,
    ST_RD,
    ST_TURN,
    ST_WS,
    ST_WP,
    ST_WH,
    ST_SLEEP,
    ST_WAKE
  } sram_state_e;

  localparam int DEF_ADDR_W     = 22;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RD_WAIT    = 3;
  localparam int DEF_WR_SETUP   = 1;
  localparam int DEF_WR_PULSE   = 3;
  localparam int DEF_WR_HOLD    = 1;
  localparam int DEF_TURNAROUND = 1;
  localparam int DEF_SLEEP_IDLE = 0;
  localparam int DEF_WAKE_CYC   = 4;
  localparam int DEF_LANES      = DEF_DATA_W / 8;

  function automatic int max6(input int a, input int b, input int c, input int d, input int e,
                              input int f);
    int m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    m = (e > m) ? e : m;
    m = (f > m) ? f : m;
    return m;
  endfunction

  // Bits needed to hold values 0..m.
  function automatic int cnt_width(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl: single-word valid/ready bus to asynchronous SRAM pin sequencer
module sram_async_ctrl
  import cram_sram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_WAIT    = DEF_RD_WAIT,
  parameter int WR_SETUP   = DEF_WR_SETUP,
  parameter int WR_PULSE   = DEF_WR_PULSE,
  parameter int WR_HOLD    = DEF_WR_HOLD,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int SLEEP_IDLE = DEF_SLEEP_IDLE,
  parameter int WAKE_CYC   = DEF_WAKE_CYC
) (
  input  logic                  clk12,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     sram_adr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_zz_n,
  output logic [DATA_W/8-1:0]   sram_dm_n,
  output logic [DATA_W-1:0]     sram_d_o,
  output logic                  sram_d_oe,
  input  logic [DATA_W-1:0]     sram_d_i
);

  localparam int BE_W = DATA_W / 8;
  localparam int CW   = cnt_width(max6(RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, TURNAROUND, WAKE_CYC));
  localparam int IW   = cnt_width(SLEEP_IDLE);

  sram_state_e     state, state_nxt;
  logic [CW-1:0]   cnt, cnt_ld;
  logic [IW-1:0]   idle_cnt;
  logic            accept, done, sleep_hit;
  logic            ce_n_d, oe_n_d, we_n_d, zz_n_d, d_oe_d, ready_d;
  logic [BE_W-1:0] dm_n_d;

  assign accept    = req_valid && req_ready;
  assign done      = cnt == '0;
  assign sleep_hit = (SLEEP_IDLE != 0) && (idle_cnt == IW'(SLEEP_IDLE - 1));

  // State, shared phase counter (reloaded on every state change) and idle run length
  always_ff @(posedge clk12) begin
    if (reset) begin
      state    <= ST_RST;
      cnt      <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= (state_nxt != state) ? cnt_ld : cnt - CW'(1);
      idle_cnt <= (SLEEP_IDLE != 0 && state == ST_IDLE && !req_valid && !sleep_hit)
                  ? idle_cnt + IW'(1) : '0;
    end
  end

  // Next state: each timed phase ends when the counter reaches zero
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:   state_nxt = ST_IDLE;
      ST_IDLE:  state_nxt = accept ? (req_we ? ST_WS : ST_RD)
                          : (!req_valid && sleep_hit) ? ST_SLEEP : ST_IDLE;
      ST_RD:    state_nxt = done ? ST_TURN : ST_RD;
      ST_TURN:  state_nxt = done ? ST_IDLE : ST_TURN;
      ST_WS:    state_nxt = done ? ST_WP : ST_WS;
      ST_WP:    state_nxt = done ? ST_WH : ST_WP;
      ST_WH:    state_nxt = done ? ST_IDLE : ST_WH;
      ST_SLEEP: state_nxt = req_valid ? ST_WAKE : ST_SLEEP;
      ST_WAKE:  state_nxt = done ? ST_IDLE : ST_WAKE;
      default:  state_nxt = ST_RST;
    endcase
  end

  // Pin values for the coming cycle, decoded from the state being entered
  always_comb begin
    cnt_ld = state_nxt == ST_RD   ? CW'(RD_WAIT - 1)
           : state_nxt == ST_TURN ? CW'(TURNAROUND - 1)
           : state_nxt == ST_WS   ? CW'(WR_SETUP - 1)
           : state_nxt == ST_WP   ? CW'(WR_PULSE - 1)
           : state_nxt == ST_WH   ? CW'(WR_HOLD - 1)
           : state_nxt == ST_WAKE ? CW'(WAKE_CYC - 1) : '0;
    d_oe_d  = state_nxt == ST_WS || state_nxt == ST_WP || state_nxt == ST_WH;
    ce_n_d  = !(d_oe_d || state_nxt == ST_RD);
    oe_n_d  = state_nxt != ST_RD;
    we_n_d  = state_nxt != ST_WP;
    zz_n_d  = state_nxt != ST_SLEEP;
    ready_d = state_nxt == ST_IDLE;
    dm_n_d  = state_nxt == ST_RD ? '0
            : d_oe_d ? (accept ? ~req_be : sram_dm_n) : '1;
  end

  // Registered pins and response; address/data frozen from accept until the next accept
  always_ff @(posedge clk12) begin
    if (reset) begin
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_zz_n <= 1'b1;
      sram_dm_n <= '1;
      sram_d_oe <= 1'b0;
      sram_adr  <= '0;
      sram_d_o  <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      sram_ce_n <= ce_n_d;
      sram_oe_n <= oe_n_d;
      sram_we_n <= we_n_d;
      sram_zz_n <= zz_n_d;
      sram_dm_n <= dm_n_d;
      sram_d_oe <= d_oe_d;
      req_ready <= ready_d;
      rsp_valid <= done && (state == ST_RD || state == ST_WH);
      if (accept) begin
        sram_adr <= req_addr;
        sram_d_o <= req_wdata;
      end
      if (done && state == ST_RD) rsp_rdata <= sram_d_i;
    end
  end

endmodule

// File: tb/tb_sram_async_ctrl.sv
// tb_sram_async_ctrl: randomized self-checking bench with a pin-level SRAM and a word-level reference memory
module tb_sram_async_ctrl;

  localparam int SLEEP = 8;

  logic        clk12 = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [21:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [21:0] sram_adr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_zz_n, sram_d_oe;
  logic [3:0]  sram_dm_n;
  logic [31:0] sram_d_o;
  logic [31:0] sram_d_i = '0;

  int nchk = 0, npass = 0, viol = 0, v0;
  logic prev_rsp = 1'b0;
  logic [31:0] pmem [int];
  logic [31:0] rmem [int];

  int wt, lat, n_ce, n_oe, n_we, first_we, dm_bad;
  logic [31:0] rd, exp;
  logic rdy_end, ce_end, doe_end;
  logic [3:0] dm_end;

  sram_async_ctrl #(.SLEEP_IDLE(SLEEP)) dut (
    .clk12(clk12), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_adr(sram_adr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_zz_n(sram_zz_n), .sram_dm_n(sram_dm_n), .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe),
    .sram_d_i(sram_d_i)
  );

  always #5 clk12 = ~clk12;

  function automatic logic [31:0] seed(input int a);
    return 32'(a) * 32'h9E37_79B1 ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [21:0] a);
    return rmem.exists(int'(a)) ? rmem[int'(a)] : seed(int'(a));
  endfunction

  function automatic void ref_wr(input logic [21:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = ref_rd(a);
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    rmem[int'(a)] = w;
  endfunction

  // Asynchronous SRAM: drives data while selected and output-enabled
  always @(negedge clk12)
    sram_d_i <= (!sram_ce_n && !sram_oe_n)
                ? (pmem.exists(int'(sram_adr)) ? pmem[int'(sram_adr)] : seed(int'(sram_adr))) : 32'h0;

  // Asynchronous SRAM: latches unmasked lanes on the rising edge of we_n
  always @(posedge sram_we_n) begin : pin_write
    logic [31:0] w;
    if (!sram_ce_n && sram_d_oe) begin
      w = pmem.exists(int'(sram_adr)) ? pmem[int'(sram_adr)] : seed(int'(sram_adr));
      for (int i = 0; i < 4; i++) if (!sram_dm_n[i]) w[8*i +: 8] = sram_d_o[8*i +: 8];
      pmem[int'(sram_adr)] = w;
    end
  end

  // Bus contention and back-to-back response pulses are protocol violations
  always @(negedge clk12) begin
    if ((sram_d_oe && !sram_oe_n) || (rsp_valid && prev_rsp)) viol <= viol + 1;
    prev_rsp <= rsp_valid;
  end

  task automatic xact(input logic we, input logic [21:0] a, input logic [31:0] wd, input logic [3:0] be);
    req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
    wt = 0; lat = -1; n_ce = 0; n_oe = 0; n_we = 0; first_we = 0; dm_bad = 0;
    rd = '0; rdy_end = 0; ce_end = 0; doe_end = 0; dm_end = '0;
    while (!req_ready && wt < 40) begin @(negedge clk12); wt++; end
    exp = ref_rd(a);
    if (!req_ready) begin
      nchk++;
      $display("FAIL accept_timeout addr=%h waited=%0d required<40", a, wt);
      req_valid = 1'b0;
      return;
    end
    if (we) begin ref_wr(a, wd, be); exp = ref_rd(a); end
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk12);
      if (c == 1) begin req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd; req_be = ~be; end
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; rdy_end = req_ready; ce_end = sram_ce_n; doe_end = sram_d_oe; dm_end = sram_dm_n;
      end else begin
        if (!sram_ce_n) n_ce++;
        if (!sram_oe_n) n_oe++;
        if (!sram_we_n) begin n_we++; if (first_we == 0) first_we = c; end
        if (!sram_ce_n && sram_dm_n !== (we ? ~be : 4'h0)) dm_bad++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0;
    repeat (3) @(negedge clk12);
    nchk++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_zz_n, sram_dm_n, sram_d_oe, req_ready, rsp_valid} !== 11'b1111_1111_000)
      $display("FAIL reset_strobes got=%b exp=11111111000", {sram_ce_n, sram_oe_n, sram_we_n, sram_zz_n, sram_dm_n, sram_d_oe, req_ready, rsp_valid});
    else npass++;
    nchk++; if ({sram_adr, sram_d_o, rsp_rdata} !== 86'h0)
      $display("FAIL reset_data adr=%h d_o=%h rdata=%h exp=0", sram_adr, sram_d_o, rsp_rdata); else npass++;
    reset = 1'b0;
    @(negedge clk12);
    nchk++; if (req_ready !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", req_ready); else npass++;
  endtask

  task automatic test_read;
    xact(1'b0, 22'h10, 32'h0, 4'h0);
    nchk++; if (wt !== 0) $display("FAIL rd_accept_wait got=%0d exp=0", wt); else npass++;
    nchk++; if (lat !== 4) $display("FAIL rd_latency got=%0d exp=4", lat); else npass++;
    nchk++; if ({n_oe, n_ce, n_we} !== {32'd3, 32'd3, 32'd0})
      $display("FAIL rd_strobes oe=%0d ce=%0d we=%0d exp=3/3/0", n_oe, n_ce, n_we); else npass++;
    nchk++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", rd); else npass++;
    nchk++; if (dm_bad !== 0) $display("FAIL rd_dm got=%0d bad cycles exp=0", dm_bad); else npass++;
    nchk++; if (rdy_end !== 1'b0) $display("FAIL rd_ready_in_turn got=%b exp=0", rdy_end); else npass++;
    @(negedge clk12);
    nchk++; if (req_ready !== 1'b1) $display("FAIL rd_ready_cycle5 got=%b exp=1", req_ready); else npass++;
  endtask

  task automatic test_write;
    v0 = viol;
    xact(1'b1, 22'h3FFFFF, 32'h12345678, 4'hF);
    nchk++; if (lat !== 6) $display("FAIL wr_latency got=%0d exp=6", lat); else npass++;
    nchk++; if ({n_we, first_we, n_ce} !== {32'd3, 32'd2, 32'd5})
      $display("FAIL wr_pulse we_cyc=%0d first=%0d ce_cyc=%0d exp=3/2/5", n_we, first_we, n_ce); else npass++;
    nchk++; if ({ce_end, doe_end, rdy_end, dm_end} !== 7'b1_0_1_1111)
      $display("FAIL wr_end ce=%b doe=%b ready=%b dm=%b exp=1 0 1 1111", ce_end, doe_end, rdy_end, dm_end); else npass++;
    xact(1'b0, 22'h3FFFFF, 32'h0, 4'h0);
    nchk++; if (rd !== 32'h12345678 || lat !== 4) $display("FAIL wr_readback got=%h lat=%0d exp=12345678 lat=4", rd, lat); else npass++;
    nchk++; if (viol !== v0) $display("FAIL wr_contention got=%0d violations exp=0", viol - v0); else npass++;
  endtask

  task automatic test_be;
    nchk++; if (sram_dm_n !== 4'hF) $display("FAIL be_dm_before got=%b exp=1111", sram_dm_n); else npass++;
    xact(1'b1, 22'h77, 32'hA1B2C3D4, 4'b0101);
    nchk++; if (dm_bad !== 0 || n_ce !== 5) $display("FAIL be_dm_during bad=%0d ce=%0d exp=0 bad 5 ce (dm=1010)", dm_bad, n_ce); else npass++;
    nchk++; if (dm_end !== 4'hF) $display("FAIL be_dm_after got=%b exp=1111", dm_end); else npass++;
    xact(1'b0, 22'h77, 32'h0, 4'h0);
    nchk++; if (rd !== exp) $display("FAIL be_readback got=%h exp=%h", rd, exp); else npass++;
  endtask

  task automatic test_random;
    logic [21:0] pool [6];
    logic w;
    logic [21:0] a;
    for (int i = 0; i < 6; i++) pool[i] = 22'($urandom);
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom);
      a = pool[$urandom_range(0, 5)];
      xact(w, a, $urandom, 4'($urandom));
      nchk++; if (lat !== (w ? 6 : 4)) $display("FAIL rand_latency n=%0d we=%b got=%0d exp=%0d", n, w, lat, w ? 6 : 4); else npass++;
      if (!w) begin
        nchk++; if (rd !== exp) $display("FAIL rand_data n=%0d addr=%h got=%h exp=%h", n, a, rd, exp); else npass++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk12);
    end
  endtask

  task automatic test_back_to_back;
    logic [21:0] ba [3];
    logic [31:0] bd [3];
    logic bw [3];
    int acc_t [$];
    int rsp_t [$];
    logic [31:0] exp_q [$];
    int i;
    logic go, pend_rd;
    ba[0] = 22'($urandom); ba[1] = ba[0]; ba[2] = 22'($urandom);
    bd[0] = $urandom; bd[1] = 32'h0; bd[2] = $urandom;
    bw[0] = 1'b1; bw[1] = 1'b0; bw[2] = 1'b1;
    i = 0; go = 0; pend_rd = 0; v0 = viol;
    req_we = bw[0]; req_addr = ba[0]; req_wdata = bd[0]; req_be = 4'hF; req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (go) begin
        go = 0; i++;
        if (i < 3) begin req_we = bw[i]; req_addr = ba[i]; req_wdata = bd[i]; end else req_valid = 1'b0;
      end
      if (rsp_valid) begin
        rsp_t.push_back(c);
        if (pend_rd) begin
          nchk++; if (rsp_rdata !== exp_q[0]) $display("FAIL b2b_data got=%h exp=%h", rsp_rdata, exp_q[0]); else npass++;
          pend_rd = 0;
        end
      end
      if (req_valid && req_ready) begin
        go = 1; acc_t.push_back(c); pend_rd = !req_we;
        if (req_we) ref_wr(req_addr, req_wdata, 4'hF); else exp_q.push_back(ref_rd(req_addr));
      end
      @(negedge clk12);
    end
    nchk++; if (acc_t.size() !== 3 || rsp_t.size() !== 3)
      $display("FAIL b2b_counts accepts=%0d rsps=%0d exp=3/3", acc_t.size(), rsp_t.size()); else npass++;
    if (acc_t.size() == 3 && rsp_t.size() == 3) begin
      nchk++; if (acc_t[1] - acc_t[0] !== 6 || acc_t[2] - acc_t[1] !== 5)
        $display("FAIL b2b_spacing got=%0d,%0d exp=6,5", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]); else npass++;
      nchk++; if (rsp_t[2] - acc_t[2] !== 6) $display("FAIL b2b_last_rsp got=%0d exp=6", rsp_t[2] - acc_t[2]); else npass++;
    end
    nchk++; if (viol !== v0) $display("FAIL b2b_protocol got=%0d violations exp=0", viol - v0); else npass++;
  endtask

  task automatic test_sleep;
    int n;
    n = 0;
    xact(1'b0, 22'h10, 32'h0, 4'h0);
    nchk++; if (lat !== 4 || rd !== exp) $display("FAIL sleep_pre_read lat=%0d data=%h exp=4 %h", lat, rd, exp); else npass++;
    while (n < 30) begin
      @(negedge clk12);
      if (!sram_zz_n) break;
      if (req_ready) n++;
    end
    nchk++; if (n !== SLEEP) $display("FAIL sleep_idle_cycles got=%0d exp=%0d", n, SLEEP); else npass++;
    nchk++; if ({sram_zz_n, req_ready} !== 2'b00) $display("FAIL sleep_entry zz_n=%b ready=%b exp=0 0", sram_zz_n, req_ready); else npass++;
    repeat (3) @(negedge clk12);
    nchk++; if (sram_zz_n !== 1'b0) $display("FAIL sleep_hold zz_n=%b exp=0", sram_zz_n); else npass++;
    xact(1'b0, 22'h5, 32'h0, 4'h0);
    nchk++; if (wt !== 5) $display("FAIL wake_cycles got=%0d exp=5 (1 sleep + 4 wake)", wt); else npass++;
    nchk++; if (rd !== exp || lat !== 4) $display("FAIL wake_read data=%h lat=%0d exp=%h lat=4", rd, lat, exp); else npass++;
  endtask

  task automatic test_reset_mid_write;
    int n;
    logic rsp_seen;
    n = 0;
    req_we = 1'b1; req_addr = 22'h2AAAAA; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
    while (!req_ready && n < 40) begin @(negedge clk12); n++; end
    @(negedge clk12);
    req_valid = 1'b0;
    @(negedge clk12);
    nchk++; if (sram_we_n !== 1'b0) $display("FAIL mid_in_pulse we_n=%b exp=0", sram_we_n); else npass++;
    reset = 1'b1;
    @(negedge clk12);
    nchk++; if ({sram_we_n, sram_ce_n, sram_d_oe, rsp_valid} !== 4'b1100)
      $display("FAIL mid_reset we_n=%b ce_n=%b d_oe=%b rsp=%b exp=1 1 0 0", sram_we_n, sram_ce_n, sram_d_oe, rsp_valid); else npass++;
    @(negedge clk12);
    rsp_seen = rsp_valid;
    reset = 1'b0;
    xact(1'b0, 22'h10, 32'h0, 4'h0);
    nchk++; if (rsp_seen !== 1'b0) $display("FAIL mid_no_rsp got=%b exp=0", rsp_seen); else npass++;
    nchk++; if (wt !== 1) $display("FAIL mid_accept_wait got=%0d exp=1", wt); else npass++;
    nchk++; if (rd !== exp || lat !== 4) $display("FAIL mid_read data=%h lat=%0d exp=%h lat=4", rd, lat, exp); else npass++;
  endtask

  initial begin
    pmem[32'h10] = 32'hDEADBEEF;
    rmem[32'h10] = 32'hDEADBEEF;
    test_reset;
    test_read;
    test_write;
    test_be;
    test_random;
    test_back_to_back;
    test_sleep;
    test_reset_mid_write;
    repeat (2) @(negedge clk12);
    nchk++; if (viol !== 0) $display("FAIL protocol_total got=%0d violations exp=0", viol); else npass++;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
